stq_alloc_ctl: RTL and testbench

- In-order allocation/retire/free controller for the 64-entry store-queue address buffer array.
- Hands out up to two entries per cycle to dispatch and drives the array's one-hot wrt0_en/wrt1_en.
- Marks retired stores passe via passe_en; frees drained entries via free_en.
- Discards unretired entries on exception and generates back-pressure to dispatch.

---
 rtl/stq_pkg.sv | 18 +
 rtl/stq_range_mask.sv | 28 ++
 rtl/stq_alloc_ctl.sv | 115 +++++++++++
 tb/tb_stq_alloc_ctl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/stq_pkg.sv
// rtl/stq_pkg.sv - shared constants, pointer type and one-hot decode for the store-queue allocator
package stq_pkg;

  localparam int STQ_BUF_COUNT = 64;
  localparam int STQ_PTR_W     = 6;
  localparam int STQ_STALL_WM  = 8;

  // Extra top bit is the wrap bit that separates full from empty.
  typedef logic [STQ_PTR_W:0] stq_ptr_t;

  function automatic logic [STQ_BUF_COUNT-1:0] stq_onehot(input logic [STQ_PTR_W-1:0] idx);
    logic [STQ_BUF_COUNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/stq_range_mask.sv
// rtl/stq_range_mask.sv - wrap-aware entry mask covering pointers [lo, hi)
module stq_range_mask
  import stq_pkg::*;
#(
  parameter int BUF_COUNT = STQ_BUF_COUNT,
  parameter int PTR_W     = STQ_PTR_W
) (
  input  logic [PTR_W:0]     i_lo,
  input  logic [PTR_W:0]     i_hi,
  output logic [BUF_COUNT-1:0] o_mask
);

  logic [PTR_W:0]   w_len;
  logic [PTR_W-1:0] w_off;

  assign w_len = i_hi - i_lo;

  // An entry is inside the range when its distance past lo is below the range length.
  always_comb begin
    o_mask = '0;
    w_off  = '0;
    for (int i = 0; i < BUF_COUNT; i++) begin
      w_off     = PTR_W'(i) - i_lo[PTR_W-1:0];
      o_mask[i] = ({1'b0, w_off} < w_len);
    end
  end

endmodule

// File: rtl/stq_alloc_ctl.sv
// rtl/stq_alloc_ctl.sv - in-order alloc/retire/drain controller for the store-queue address buffer
// Optional STQ_ALLOC_WATERMARK_EN: stall dispatch once free space falls below STALL_WM.
module stq_alloc_ctl
  import stq_pkg::*;
#(
  parameter int BUF_COUNT = STQ_BUF_COUNT,
  parameter int PTR_W     = STQ_PTR_W
`ifdef STQ_ALLOC_WATERMARK_EN
  ,
  parameter int STALL_WM  = STQ_STALL_WM
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 excpt,
  input  logic [1:0]           alloc_req,
  output logic [1:0]           alloc_gnt,
  output logic [PTR_W-1:0]     alloc_idx0,
  output logic [PTR_W-1:0]     alloc_idx1,
  output logic [BUF_COUNT-1:0] wrt0_en,
  output logic [BUF_COUNT-1:0] wrt1_en,
  input  logic [1:0]           retire_cnt,
  output logic [BUF_COUNT-1:0] passe_en,
  input  logic                 drain_ack,
  output logic [BUF_COUNT-1:0] free_en,
  output logic [PTR_W:0]       count,
  output logic                 empty,
  output logic                 full,
  output logic                 stallA
);

`ifdef STQ_ALLOC_WATERMARK_EN
  localparam logic [PTR_W:0] STALL_THR = (PTR_W+1)'(STALL_WM);
`else
  localparam logic [PTR_W:0] STALL_THR = (PTR_W+1)'(2);
`endif
  localparam logic [PTR_W:0] BUF_SIZE = (PTR_W+1)'(BUF_COUNT);

  stq_ptr_t             r_head, r_ret, r_tail;
  logic [PTR_W:0]       r_count;
  logic                 r_empty, r_full, r_stall;

  logic [PTR_W:0]       w_space, w_unret, w_passe_cnt, w_space_n;
  logic                 w_live, w_gnt0, w_gnt1, w_drain;
  logic [1:0]           w_ret_req, w_n;
  stq_ptr_t             w_slot1, w_ret1, w_head_n, w_ret_n, w_tail_n;
  logic [BUF_COUNT-1:0] w_flush_mask;

  assign w_live      = ~rst & ~excpt;
  assign w_space     = BUF_SIZE - (r_tail - r_head);
  assign w_unret     = r_tail - r_ret;
  assign w_passe_cnt = r_ret - r_head;

  // Slot1 only takes the second free entry when slot0 also asked for one.
  assign w_gnt0  = w_live & alloc_req[0] & (w_space != '0);
  assign w_gnt1  = w_live & alloc_req[1] &
                   (w_space >= (alloc_req[0] ? (PTR_W+1)'(2) : (PTR_W+1)'(1)));
  assign w_slot1 = r_tail + stq_ptr_t'(w_gnt0);

  assign w_ret_req = (retire_cnt > 2'd2) ? 2'd2 : retire_cnt;
  assign w_n       = ~w_live ? 2'd0 :
                     (w_unret < (PTR_W+1)'(w_ret_req)) ? w_unret[1:0] : w_ret_req;
  assign w_ret1    = r_ret + stq_ptr_t'(1);
  assign w_drain   = ~rst & drain_ack & (w_passe_cnt != '0);

  assign w_head_n  = r_head + stq_ptr_t'(w_drain);
  assign w_ret_n   = r_ret + stq_ptr_t'(w_n);
  assign w_tail_n  = excpt ? r_ret : (r_tail + stq_ptr_t'(w_gnt0) + stq_ptr_t'(w_gnt1));
  assign w_space_n = BUF_SIZE - (w_tail_n - w_head_n);

  stq_range_mask #(
    .BUF_COUNT(BUF_COUNT),
    .PTR_W    (PTR_W)
  ) u_flush_mask (
    .i_lo  (r_ret),
    .i_hi  (r_tail),
    .o_mask(w_flush_mask)
  );

  assign alloc_gnt  = {w_gnt1, w_gnt0};
  assign alloc_idx0 = r_tail[PTR_W-1:0];
  assign alloc_idx1 = w_slot1[PTR_W-1:0];
  assign wrt0_en    = w_gnt0 ? stq_onehot(r_tail[PTR_W-1:0]) : '0;
  assign wrt1_en    = w_gnt1 ? stq_onehot(w_slot1[PTR_W-1:0]) : '0;
  assign passe_en   = ((w_n != 2'd0) ? stq_onehot(r_ret[PTR_W-1:0]) : '0) |
                      ((w_n == 2'd2) ? stq_onehot(w_ret1[PTR_W-1:0]) : '0);
  assign free_en    = (w_drain ? stq_onehot(r_head[PTR_W-1:0]) : '0) |
                      ((~rst & excpt) ? w_flush_mask : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_ret   <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_head  <= w_head_n;
      r_ret   <= w_ret_n;
      r_tail  <= w_tail_n;
      r_count <= w_tail_n - w_head_n;
      r_empty <= (w_tail_n == w_head_n);
      r_full  <= (w_space_n == '0);
      r_stall <= (w_space_n < STALL_THR);
    end
  end

  assign count  = r_count;
  assign empty  = r_empty;
  assign full   = r_full;
  assign stallA = r_stall;

endmodule

// File: tb/tb_stq_alloc_ctl.sv
// tb/tb_stq_alloc_ctl.sv - randomized self-checking bench for stq_alloc_ctl against a pointer-count model
module tb_stq_alloc_ctl;

  localparam int N = 64;
`ifdef STQ_ALLOC_WATERMARK_EN
  localparam int THR = 8;
`else
  localparam int THR = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, excpt, drain_ack;
  logic [1:0]  alloc_req, retire_cnt;
  logic [1:0]  alloc_gnt;
  logic [5:0]  alloc_idx0, alloc_idx1;
  logic [63:0] wrt0_en, wrt1_en, passe_en, free_en;
  logic [6:0]  count;
  logic        empty, full, stallA;

  int n_checks = 0;
  int n_errors = 0;
  // Model: unbounded running totals of allocated / retired / freed entries.
  int m_head, m_ret, m_tail;

  always #5 clk = ~clk;

  stq_alloc_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .excpt     (excpt),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_idx0(alloc_idx0),
    .alloc_idx1(alloc_idx1),
    .wrt0_en   (wrt0_en),
    .wrt1_en   (wrt1_en),
    .retire_cnt(retire_cnt),
    .passe_en  (passe_en),
    .drain_ack (drain_ack),
    .free_en   (free_en),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .stallA    (stallA)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bit_at(input int k);
    logic [63:0] v;
    v        = '0;
    v[k % N] = 1'b1;
    return v;
  endfunction

  task automatic step(input logic r, input logic [1:0] req, input logic [1:0] rc,
                      input logic da, input logic ex);
    bit          g0, g1, dr;
    int          space, n, i1, cnt;
    logic [63:0] e_w0, e_w1, e_p, e_f;
    @(negedge clk);
    rst = r; alloc_req = req; retire_cnt = rc; drain_ack = da; excpt = ex;
    #1;
    space = N - (m_tail - m_head);
    if (r) begin
      g0 = 1'b0; g1 = 1'b0; dr = 1'b0; n = 0;
    end else begin
      g0 = !ex && req[0] && space >= 1;
      g1 = !ex && req[1] && space >= (req[0] ? 2 : 1);
      n  = ex ? 0 : ((int'(rc) < (m_tail - m_ret)) ? int'(rc) : (m_tail - m_ret));
      dr = da && (m_ret > m_head);
    end
    i1   = g0 ? m_tail + 1 : m_tail;
    e_w0 = g0 ? bit_at(m_tail) : '0;
    e_w1 = g1 ? bit_at(i1) : '0;
    e_p  = '0;
    if (n >= 1) e_p |= bit_at(m_ret);
    if (n == 2) e_p |= bit_at(m_ret + 1);
    e_f  = '0;
    if (dr) e_f |= bit_at(m_head);
    if (ex && !r) for (int k = m_ret; k < m_tail; k++) e_f |= bit_at(k);

    chk("alloc_gnt", {62'b0, alloc_gnt}, {62'b0, g1, g0});
    if (!r) begin
      chk("alloc_idx0", {58'b0, alloc_idx0}, 64'(m_tail % N));
      chk("alloc_idx1", {58'b0, alloc_idx1}, 64'(i1 % N));
    end
    chk("wrt0_en",  wrt0_en,  e_w0);
    chk("wrt1_en",  wrt1_en,  e_w1);
    chk("passe_en", passe_en, e_p);
    chk("free_en",  free_en,  e_f);

    @(posedge clk);
    #1;
    if (r) begin
      m_head = 0; m_ret = 0; m_tail = 0;
    end else begin
      m_head += int'(dr);
      if (ex) m_tail = m_ret;
      else begin
        m_ret  += n;
        m_tail += int'(g0) + int'(g1);
      end
    end
    cnt = m_tail - m_head;
    chk("count",  {57'b0, count},  64'(cnt));
    chk("empty",  {63'b0, empty},  {63'b0, (cnt == 0)});
    chk("full",   {63'b0, full},   {63'b0, (cnt == N)});
    chk("stallA", {63'b0, stallA}, {63'b0, ((N - cnt) < THR)});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    rst = 1'b1; excpt = 1'b0; alloc_req = '0; retire_cnt = '0; drain_ack = 1'b0;
    m_head = 0; m_ret = 0; m_tail = 0;

    step(1'b1, 2'b11, 2'd2, 1'b1, 1'b1);
    step(1'b1, 2'b11, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 32; i++) step(1'b0, 2'b11, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) step(1'b0, 2'b00, 2'd2, 1'b1, 1'b0);

    for (int i = 0; i < 63; i++) step(1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'b11, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) step(1'b0, 2'b00, 2'd2, 1'b1, 1'b0);
    step(1'b0, 2'b01, 2'd0, 1'b0, 1'b0);

    step(1'b1, 2'b00, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b11, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'd2, 1'b0, 1'b0);
    step(1'b0, 2'b11, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 2'd0, 1'b0, 1'b0);

    step(1'b0, 2'b00, 2'd0, 1'b1, 1'b0);
    step(1'b0, 2'b11, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'd1, 1'b0, 1'b0);
    step(1'b0, 2'b11, 2'd1, 1'b1, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      mode = (c / 150) % 2;
      step(($urandom_range(0, 199) == 0),
           (mode == 1 || $urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
           2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
